mul_rs_scheduler: RTL and testbench
===================================

Name: mul_rs_scheduler

Overview:
- Issue controller for the multiply/divide execution unit.
- Each cycle it picks one ready entry from the multiply reservation station (round-robin) and marks that entry free. It then sequences the non-pipelined mul/div datapath for a fixed per-op latency and holds the result on the common data bus (CDB) until the bus arbiter grants it.
- Sits between the mul reservation station array and the CDB/ROB writeback path.

Parameters:
- NUM_RS, 3, number of reservation-station entries (2..8)
- MUL_LAT, 2, cycles from issue edge to cdb_req for func 4'b0010 (>=1)
- DIV_LAT, 4, cycles from issue edge to cdb_req for func 4'b0011 (>=1)

Ports:
- clk1  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  squash in-flight op (branch mispredict / ROB flush)
- rs_valid  in  NUM_RS  entry occupied
- rs_ready  in  NUM_RS  both source operands available
- rs_func  in  4*NUM_RS  per-entry func, entry i at [4i+3:4i]
- rs_a  in  8*NUM_RS  per-entry operand 1
- rs_b  in  8*NUM_RS  per-entry operand 2
- rs_rob  in  3*NUM_RS  per-entry ROB index
- rs_rd  in  4*NUM_RS  per-entry destination register
- rs_free  out  NUM_RS  one-hot, one-cycle pulse: entry issued, clear its busy bit
- busy  out  1  unit occupied (state != IDLE)
- cdb_req  out  1  result valid, requesting CDB
- cdb_grant  in  1  CDB arbiter grant
- cdb_data  out  16  result
- cdb_rob  out  3  ROB index of result
- cdb_rd  out  4  destination register of result
- cdb_exc  out  1  divide-by-zero or illegal func

Behaviour:
- Reset (async, rst_n=0) drives:
  - state=IDLE, rr_ptr=0
  - rs_free=0, busy=0, cdb_req=0, cdb_data=0, cdb_rob=0, cdb_rd=0, cdb_exc=0
- Deassertion of rst_n takes effect at the next posedge.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - Candidate set = rs_valid & rs_ready.
  - Select the first set bit searching from rr_ptr upward, wrapping at NUM_RS.
  - If a candidate exists, at the edge: latch func/a/b/rob/rd of the selected entry, assert rs_free[sel] for exactly the following cycle, set rr_ptr=(sel+1) mod NUM_RS, load cnt=LAT-1, go to EXEC.
  - LAT is MUL_LAT for func 0010, DIV_LAT for 0011, and 1 for any other func.
  - No candidate: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - If cnt!=0, decrement.
  - If cnt==0, at the edge: compute the result, drive the cdb_* outputs, set cdb_req=1, go to WB.
  - Result: cdb_req rises exactly LAT cycles after the issue edge.
- Arithmetic (unsigned):
  - 0010: 8x8 -> full 16-bit product.
  - 0011: quotient a/b zero-extended to 16 bits.
  - b==0 on divide: data=16'hFFFF, cdb_exc=1.
  - Any other func: data=0, cdb_exc=1.
- WB:
  - cdb_req and cdb_* hold stable until cdb_grant is sampled high.
  - At the grant edge: cdb_req=0, go to IDLE. Next issue no earlier than the following edge, giving a 1-cycle bubble.
  - Grant while cdb_req=0 is ignored.
- busy=1 in EXEC and WB; rs_free never asserts outside the cycle after an IDLE issue.
- Operand inputs are sampled only at the issue edge. RS changes after issue have no effect.
- flush=1 at an edge, any state: go to IDLE, cdb_req=0, no writeback, rr_ptr retained.
  - A flush at the same edge as an IDLE issue suppresses the issue: no rs_free, no latch.
  - A flush in WB coinciding with cdb_grant: flush wins, cdb_req drops.
- An entry with rs_valid=1 and rs_ready=0 is skipped, with no starvation of others.
- rs_valid=0 entries are never selected regardless of rs_ready.

Test Plan:
1. Reset then single mul: entry0 valid/ready, func 0010, a=8'd12, b=8'd11, rob=3, rd=5; cdb_grant tied 1 -> rs_free=3'b001 one cycle after issue edge, cdb_req high 2 cycles after issue, cdb_data=16'd132, rob=3, rd=5, exc=0.
2. Divide and divide-by-zero: a=200, b=7 -> data=16'd28 after 4 cycles; then a=9, b=0 -> data=16'hFFFF, cdb_exc=1.
3. Round-robin: all 3 entries ready continuously, grant=1 -> issue order 0,1,2,0; rr_ptr wraps; rs_free one-hot each time.
4. CDB backpressure: cdb_grant held 0 for 5 cycles after cdb_req -> cdb_req and data stable 5 cycles; no rs_free; issue resumes the cycle after grant.
5. Flush mid-EXEC of a divide (cycle 2 of 4) -> cdb_req never asserts, busy=0 next cycle; a pending ready entry issues afterwards with a correct result.
6. Async reset asserted in WB with cdb_req=1 -> cdb_req/busy drop immediately, without a clock edge; all outputs return to 0.

Source files
------------

// File: rtl/mul_rs_scheduler.sv
// mul_rs_scheduler
//   Issue controller for the non-pipelined multiply/divide unit. Picks one
//   ready reservation-station entry per issue (round-robin), frees that
//   entry, runs the operation for its fixed latency, then holds the result
//   on the CDB until the arbiter grants it.
//
// Ports
//   clk1, rst_n        clock (posedge) and asynchronous active-low reset
//   flush              squash any in-flight op and return to IDLE
//   rs_valid/rs_ready  per-entry occupied / operands-available flags
//   rs_func/a/b/rob/rd per-entry packed fields, entry i at [W*i +: W]
//   rs_free            one-hot, one-cycle pulse: entry i was issued
//   busy               unit occupied (EXEC or WB)
//   cdb_req            result valid, requesting the CDB
//   cdb_grant          CDB arbiter grant (only meaningful while cdb_req=1)
//   cdb_data/rob/rd    result, its ROB index and destination register
//   cdb_exc            divide-by-zero or illegal func

module mul_rs_scheduler #(
  parameter int NUM_RS  = 3,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [NUM_RS-1:0]   rs_valid,
  input  logic [NUM_RS-1:0]   rs_ready,
  input  logic [4*NUM_RS-1:0] rs_func,
  input  logic [8*NUM_RS-1:0] rs_a,
  input  logic [8*NUM_RS-1:0] rs_b,
  input  logic [3*NUM_RS-1:0] rs_rob,
  input  logic [4*NUM_RS-1:0] rs_rd,
  output logic [NUM_RS-1:0]   rs_free,
  output logic                busy,
  output logic                cdb_req,
  input  logic                cdb_grant,
  output logic [15:0]         cdb_data,
  output logic [2:0]          cdb_rob,
  output logic [3:0]          cdb_rd,
  output logic                cdb_exc
);

  localparam int PTR_W   = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [3:0]       FUNC_MUL = 4'b0010;
  localparam logic [3:0]       FUNC_DIV = 4'b0011;
  localparam logic [PTR_W:0]   NUM_RS_W = (PTR_W+1)'(NUM_RS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_RS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt;

  // Operands captured at the issue edge; the RS may change afterwards.
  logic [3:0]         op_func;
  logic [7:0]         op_a;
  logic [7:0]         op_b;
  logic [2:0]         op_rob;
  logic [3:0]         op_rd;

  // Per-entry views of the packed RS buses.
  logic [3:0]         func_arr [NUM_RS];
  logic [7:0]         a_arr    [NUM_RS];
  logic [7:0]         b_arr    [NUM_RS];
  logic [2:0]         rob_arr  [NUM_RS];
  logic [3:0]         rd_arr   [NUM_RS];

  for (genvar g = 0; g < NUM_RS; g++) begin : g_unpack
    assign func_arr[g] = rs_func[4*g +: 4];
    assign a_arr[g]    = rs_a[8*g +: 8];
    assign b_arr[g]    = rs_b[8*g +: 8];
    assign rob_arr[g]  = rs_rob[3*g +: 3];
    assign rd_arr[g]   = rs_rd[4*g +: 4];
  end

  // Issue latency minus one, loaded into cnt so that cdb_req rises exactly
  // LAT edges after the issue edge.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] f);
    case (f)
      FUNC_MUL: return CNT_W'(MUL_LAT - 1);
      FUNC_DIV: return CNT_W'(DIV_LAT - 1);
      default:  return '0;
    endcase
  endfunction

  // ------------------------------------------------------------------
  // Round-robin pick: first candidate at or above rr_ptr, wrapping.
  // ------------------------------------------------------------------
  logic [NUM_RS-1:0] cand;
  logic              found;
  logic [PTR_W-1:0]  sel;
  logic [PTR_W:0]    idx;

  assign cand = rs_valid & rs_ready;

  // NOTE: every variable driven here gets a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= NUM_RS_W) idx = idx - NUM_RS_W;
      if (!found && cand[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[PTR_W-1:0];
      end
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic. flush overrides everything and also blocks an issue
  // or a writeback that would otherwise happen at the same edge.
  // ------------------------------------------------------------------
  logic issue;
  logic finish;

  always_comb begin
    state_d = state;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state)
      S_IDLE: begin
        if (found && !flush) begin
          issue   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt == '0) begin
          finish  = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (flush || cdb_grant) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Result computation from the captured operands.
  // ------------------------------------------------------------------
  logic [15:0] res_data;
  logic        res_exc;

  always_comb begin
    res_data = 16'h0000;
    res_exc  = 1'b1;
    case (op_func)
      FUNC_MUL: begin
        res_data = {8'h00, op_a} * {8'h00, op_b};
        res_exc  = 1'b0;
      end
      FUNC_DIV: begin
        if (op_b == 8'h00) begin
          res_data = 16'hFFFF;
        end else begin
          res_data = {8'h00, op_a / op_b};
          res_exc  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------
  // State and datapath registers.
  // ------------------------------------------------------------------
  // NOTE: these are a handful of control/datapath flops, not a storage
  // array, so all of them are reset and every output reads 0 in reset.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      op_func  <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_rob   <= '0;
      op_rd    <= '0;
      rs_free  <= '0;
      cdb_req  <= 1'b0;
      cdb_data <= '0;
      cdb_rob  <= '0;
      cdb_rd   <= '0;
      cdb_exc  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state   <= state_d;
      rs_free <= '0;
      cdb_req <= (state_d == S_WB);

      if (issue) begin
        op_func <= func_arr[sel];
        op_a    <= a_arr[sel];
        op_b    <= b_arr[sel];
        op_rob  <= rob_arr[sel];
        op_rd   <= rd_arr[sel];
        cnt     <= lat_m1(func_arr[sel]);
        rs_free <= {{(NUM_RS-1){1'b0}}, 1'b1} << sel;
        rr_ptr  <= (sel == LAST_IDX) ? '0 : sel + PTR_W'(1);
      end else if (state == S_EXEC && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (finish) begin
        cdb_data <= res_data;
        cdb_exc  <= res_exc;
        cdb_rob  <= op_rob;
        cdb_rd   <= op_rd;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mul_rs_scheduler.sv
// Testbench for mul_rs_scheduler: directed stimulus, scoreboard queue of
// expected CDB results, and an independent monitor that pops and compares
// whenever cdb_req rises (and checks the result holds while it stays up).

module tb_mul_rs_scheduler;

  localparam int NUM_RS  = 3;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;

  logic                clk1;
  logic                rst_n;
  logic                flush;
  logic [NUM_RS-1:0]   rs_valid;
  logic [NUM_RS-1:0]   rs_ready;
  logic [4*NUM_RS-1:0] rs_func;
  logic [8*NUM_RS-1:0] rs_a;
  logic [8*NUM_RS-1:0] rs_b;
  logic [3*NUM_RS-1:0] rs_rob;
  logic [4*NUM_RS-1:0] rs_rd;
  logic [NUM_RS-1:0]   rs_free;
  logic                busy;
  logic                cdb_req;
  logic                cdb_grant;
  logic [15:0]         cdb_data;
  logic [2:0]          cdb_rob;
  logic [3:0]          cdb_rd;
  logic                cdb_exc;

  mul_rs_scheduler #(
    .NUM_RS (NUM_RS),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .flush    (flush),
    .rs_valid (rs_valid),
    .rs_ready (rs_ready),
    .rs_func  (rs_func),
    .rs_a     (rs_a),
    .rs_b     (rs_b),
    .rs_rob   (rs_rob),
    .rs_rd    (rs_rd),
    .rs_free  (rs_free),
    .busy     (busy),
    .cdb_req  (cdb_req),
    .cdb_grant(cdb_grant),
    .cdb_data (cdb_data),
    .cdb_rob  (cdb_rob),
    .cdb_rd   (cdb_rd),
    .cdb_exc  (cdb_exc)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int issue_cyc = 0;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rob;
    logic [3:0]  rd;
    logic        exc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [2:0] rob,
                          input logic [3:0] rd, input logic exc, input int lat);
    exp_t e;
    e.data = d; e.rob = rob; e.rd = rd; e.exc = exc; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic set_entry(input int i, input logic v, input logic r,
                           input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] rob, input logic [3:0] rd);
    rs_valid[i]       = v;
    rs_ready[i]       = r;
    rs_func[4*i +: 4] = f;
    rs_a[8*i +: 8]    = a;
    rs_b[8*i +: 8]    = b;
    rs_rob[3*i +: 3]  = rob;
    rs_rd[4*i +: 4]   = rd;
  endtask

  // Wait for an rs_free pulse, check its mask, optionally retire the entry
  // (as the RS would), then confirm the pulse lasted a single cycle.
  task automatic wait_free(input string name, input logic [NUM_RS-1:0] exp, input logic clr);
    int n = 0;
    do begin
      @(negedge clk1);
      n++;
    end while (rs_free == '0 && n < 40);
    if (rs_free == '0) begin
      check({name, "_timeout"}, 32'(rs_free), 32'(exp));
    end else begin
      issue_cyc = cyc;
      check(name, 32'(rs_free), 32'(exp));
      check({name, "_busy"}, 32'(busy), 32'd1);
      if (clr) rs_valid = rs_valid & ~rs_free;
      @(negedge clk1);
      check({name, "_pulse"}, 32'(rs_free), 32'd0);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk1);
      n++;
    end
    if (busy) check({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!cdb_req && n < 40) begin
      @(negedge clk1);
      n++;
    end
    if (!cdb_req) check({name, "_req_timeout"}, 32'(cdb_req), 32'd1);
  endtask

  // Scoreboard monitor: compare on the rising cdb_req, then check that the
  // presented result holds for as long as cdb_req stays high.
  initial begin : monitor
    exp_t cur;
    logic req_q;
    req_q = 1'b0;
    cur.data = '0; cur.rob = '0; cur.rd = '0; cur.exc = 1'b0; cur.lat = 0;
    forever begin
      @(negedge clk1);
      if (cdb_req && !req_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", 32'(cdb_req), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("wb_data", 32'(cdb_data), 32'(cur.data));
          check("wb_rob", 32'(cdb_rob), 32'(cur.rob));
          check("wb_rd", 32'(cdb_rd), 32'(cur.rd));
          check("wb_exc", 32'(cdb_exc), 32'(cur.exc));
          check("wb_latency", 32'(cyc - issue_cyc), 32'(cur.lat));
        end
      end else if (cdb_req) begin
        check("hold_data", 32'(cdb_data), 32'(cur.data));
        check("hold_rob", 32'(cdb_rob), 32'(cur.rob));
        check("hold_exc", 32'(cdb_exc), 32'(cur.exc));
      end
      req_q = cdb_req;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int grant_cyc;
    rst_n     = 1'b0;
    flush     = 1'b0;
    cdb_grant = 1'b0;
    rs_valid  = '0;
    rs_ready  = '0;
    rs_func   = '0;
    rs_a      = '0;
    rs_b      = '0;
    rs_rob    = '0;
    rs_rd     = '0;

    // Reset state
    repeat (2) @(negedge clk1);
    check("rst_free", 32'(rs_free), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(cdb_req), 32'd0);
    check("rst_data", 32'(cdb_data), 32'd0);
    check("rst_rob", 32'(cdb_rob), 32'd0);
    check("rst_rd", 32'(cdb_rd), 32'd0);
    check("rst_exc", 32'(cdb_exc), 32'd0);
    @(posedge clk1); #1;
    rst_n = 1'b1;
    @(negedge clk1);

    // 1: single multiply, grant tied high
    cdb_grant = 1'b1;
    set_entry(0, 1'b1, 1'b1, 4'b0010, 8'd12, 8'd11, 3'd3, 4'd5);
    push_exp(16'd132, 3'd3, 4'd5, 1'b0, MUL_LAT);
    wait_free("t1_free", 3'b001, 1'b1);
    wait_idle("t1");

    // 2: divide, then divide by zero
    set_entry(1, 1'b1, 1'b1, 4'b0011, 8'd200, 8'd7, 3'd1, 4'd2);
    push_exp(16'd28, 3'd1, 4'd2, 1'b0, DIV_LAT);
    wait_free("t2_div_free", 3'b010, 1'b1);
    wait_idle("t2_div");
    set_entry(2, 1'b1, 1'b1, 4'b0011, 8'd9, 8'd0, 3'd2, 4'd7);
    push_exp(16'hFFFF, 3'd2, 4'd7, 1'b1, DIV_LAT);
    wait_free("t2_dz_free", 3'b100, 1'b1);
    wait_idle("t2_dz");

    // 3: round-robin with all entries ready continuously
    set_entry(0, 1'b1, 1'b1, 4'b0010, 8'd3, 8'd4, 3'd0, 4'd1);
    set_entry(1, 1'b1, 1'b1, 4'b0010, 8'd255, 8'd255, 3'd1, 4'd2);
    set_entry(2, 1'b1, 1'b1, 4'b0010, 8'd16, 8'd16, 3'd2, 4'd3);
    push_exp(16'd12, 3'd0, 4'd1, 1'b0, MUL_LAT);
    push_exp(16'hFE01, 3'd1, 4'd2, 1'b0, MUL_LAT);
    push_exp(16'd256, 3'd2, 4'd3, 1'b0, MUL_LAT);
    push_exp(16'd12, 3'd0, 4'd1, 1'b0, MUL_LAT);
    wait_free("t3_rr0", 3'b001, 1'b0);
    wait_free("t3_rr1", 3'b010, 1'b0);
    wait_free("t3_rr2", 3'b100, 1'b0);
    wait_free("t3_rr3", 3'b001, 1'b1);
    rs_valid = '0;
    rs_ready = '0;
    wait_idle("t3");

    // Skip valid-but-not-ready and never pick invalid entries; illegal func
    set_entry(0, 1'b0, 1'b1, 4'b0010, 8'd1, 8'd1, 3'd0, 4'd0);
    set_entry(1, 1'b1, 1'b0, 4'b0010, 8'd7, 8'd9, 3'd5, 4'd6);
    set_entry(2, 1'b1, 1'b1, 4'b0111, 8'd5, 8'd5, 3'd4, 4'd1);
    push_exp(16'd0, 3'd4, 4'd1, 1'b1, 1);
    wait_free("skip_free", 3'b100, 1'b1);
    wait_idle("skip");
    rs_ready[1] = 1'b1;
    push_exp(16'd63, 3'd5, 4'd6, 1'b0, MUL_LAT);
    wait_free("skip_late_free", 3'b010, 1'b1);
    wait_idle("skip_late");
    rs_ready = '0;

    // 4: CDB backpressure
    cdb_grant = 1'b0;
    set_entry(2, 1'b1, 1'b1, 4'b0010, 8'd100, 8'd3, 3'd6, 4'd9);
    push_exp(16'd300, 3'd6, 4'd9, 1'b0, MUL_LAT);
    wait_free("t4_free", 3'b100, 1'b1);
    wait_req("t4");
    set_entry(0, 1'b1, 1'b1, 4'b0011, 8'd50, 8'd5, 3'd7, 4'd0);
    push_exp(16'd10, 3'd7, 4'd0, 1'b0, DIV_LAT);
    for (int i = 0; i < 5; i++) begin
      check("t4_req_held", 32'(cdb_req), 32'd1);
      check("t4_no_free", 32'(rs_free), 32'd0);
      @(negedge clk1);
    end
    cdb_grant = 1'b1;
    @(negedge clk1);
    grant_cyc = cyc;
    check("t4_req_drop", 32'(cdb_req), 32'd0);
    check("t4_bubble", 32'(busy), 32'd0);
    wait_free("t4_resume_free", 3'b001, 1'b1);
    check("t4_resume_cycle", 32'(issue_cyc), 32'(grant_cyc + 1));
    wait_idle("t4");

    // 5: flush on the second EXEC edge of a divide, then a flush that
    // coincides with an IDLE issue, then normal issue with rr_ptr retained
    set_entry(1, 1'b1, 1'b1, 4'b0011, 8'd99, 8'd9, 3'd0, 4'd3);
    wait_free("t5_div_free", 3'b010, 1'b1);
    flush = 1'b1;
    set_entry(0, 1'b1, 1'b1, 4'b0011, 8'd255, 8'd1, 3'd2, 4'd8);
    set_entry(2, 1'b1, 1'b1, 4'b0010, 8'd13, 8'd13, 3'd3, 4'd4);
    @(negedge clk1);
    check("t5_flush_busy", 32'(busy), 32'd0);
    check("t5_flush_req", 32'(cdb_req), 32'd0);
    @(negedge clk1);
    check("t5_sup_free", 32'(rs_free), 32'd0);
    check("t5_sup_busy", 32'(busy), 32'd0);
    flush = 1'b0;
    push_exp(16'd169, 3'd3, 4'd4, 1'b0, MUL_LAT);
    wait_free("t5_after_free", 3'b100, 1'b1);
    wait_idle("t5_after");
    push_exp(16'd255, 3'd2, 4'd8, 1'b0, DIV_LAT);
    wait_free("t5_next_free", 3'b001, 1'b1);
    wait_idle("t5_next");

    // 6: asynchronous reset while holding a result in WB
    cdb_grant = 1'b0;
    set_entry(1, 1'b1, 1'b1, 4'b0010, 8'd2, 8'd3, 3'd1, 4'd1);
    push_exp(16'd6, 3'd1, 4'd1, 1'b0, MUL_LAT);
    wait_free("t6_free", 3'b010, 1'b1);
    wait_req("t6");
    @(negedge clk1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req", 32'(cdb_req), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_data", 32'(cdb_data), 32'd0);
    check("t6_rob", 32'(cdb_rob), 32'd0);
    check("t6_rd", 32'(cdb_rd), 32'd0);
    check("t6_exc", 32'(cdb_exc), 32'd0);
    check("t6_free", 32'(rs_free), 32'd0);
    @(posedge clk1); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk1);
    check("t6_post_busy", 32'(busy), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
